// File: rtl/iter_mul_unit.sv
// iter_mul_unit
//   Single-clock iterative multiplier that sits beside the execute-stage ALU.
//   Each cycle it retires STEP multiplier bits. A product takes N = WIDTH/STEP
//   cycles from accept to out_valid. Signed operands are reduced to magnitudes
//   on accept, and the product is negated on the final iteration.
//
// Ports
//   clock        sole clock, rising-edge
//   reset        synchronous, active-high, highest priority
//   in_valid     operands/mode valid        in_ready   unit can accept this cycle
//   op_a         multiplicand (WIDTH)       op_b       multiplier (WIDTH)
//   signed_mode  1 = two's complement, 0 = unsigned
//   flush        abandon any in-flight or held operation
//   out_valid    product valid              out_ready  consumer takes product
//   product      full 2*WIDTH result        busy       state is RUN or DONE
module iter_mul_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 signed_mode,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = $clog2(2 * WIDTH) + 1;
  localparam int PP_W  = WIDTH + STEP;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;

  // Magnitude of a WIDTH-bit operand. The most-negative value maps to
  // 2^(WIDTH-1), which is representable as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (is_signed && (sv < 0)) begin
      return WIDTH'(-sv);
    end
    return v;
  endfunction

  // Two's-complement negation modulo 2^(2*WIDTH) when neg is set.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic signed [WIDTH-1:0] op_a_s, op_b_s;
  logic                    accept;
  logic                    last_iter;
  logic [PP_W-1:0]         pp;
  logic [SH_W-1:0]         shamt;
  logic [2*WIDTH-1:0]      acc_sum;

  assign op_a_s    = op_a;
  assign op_b_s    = op_b;
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign last_iter = (cnt_q == CNT_W'(N - 1));
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

  // One WIDTH x STEP partial product aligned to the current digit position.
  assign pp      = PP_W'(mcand_q) * PP_W'(mplier_q[STEP-1:0]);
  assign shamt   = SH_W'(cnt_q) * SH_W'(STEP);
  assign acc_sum = acc_q + ((2 * WIDTH)'(pp) << shamt);

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    product_d   = product_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d    = acc_sum;
          mplier_d = mplier_q >> STEP;
          cnt_d    = cnt_q + 1'b1;
          if (last_iter) begin
            product_d   = apply_sign(acc_sum, neg_q);
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the IDLE fall-through of a DONE handshake.
    if (accept) begin
      mcand_d  = magnitude(op_a, signed_mode);
      mplier_d = magnitude(op_b, signed_mode);
      neg_d    = signed_mode && ((op_a_s < 0) != (op_b_s < 0));
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = S_RUN;
    end
  end

  // Control and visible outputs: reset-controlled.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      cnt_q       <= cnt_d;
    end
  end

  // Datapath working registers: always reloaded on accept before use.
  always_ff @(posedge clock) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    neg_q    <= neg_d;
    acc_q    <= acc_d;
  end

endmodule

// File: tb/tb_iter_mul_unit.sv
module tb_iter_mul_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [63:0] p;
    logic [31:0] cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic        sm_s        [3];
  logic        flush_s     [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic        busy_s      [3];
  logic [31:0] opa_s       [3];
  logic [31:0] opb_s       [3];
  logic [63:0] prod_s      [3];

  always #5 clock = ~clock;

  // Lane 0: STEP=1, lane 1: STEP=2, lane 2: STEP=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    iter_mul_unit #(.WIDTH(W), .STEP(1 << g)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid_s[g]),
      .in_ready    (in_ready_s[g]),
      .op_a        (opa_s[g]),
      .op_b        (opb_s[g]),
      .signed_mode (sm_s[g]),
      .flush       (flush_s[g]),
      .out_valid   (out_valid_s[g]),
      .out_ready   (out_ready_s[g]),
      .product     (prod_s[g]),
      .busy        (busy_s[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int nlat(input int l);
    return 32 >> l;
  endfunction

  // Reference: plain full-width multiplication of the interpreted operands.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Scoreboard: one queue of expected products per lane.
  exp_t sbq [3][$];

  // Input-side tracker: pushes an expectation for every accepted operation
  // and drops it when the operation is flushed or reset away.
  always @(negedge clock) begin
    for (int l = 0; l < 3; l++) begin
      if (reset) begin
        sbq[l].delete();
      end else if (flush_s[l]) begin
        if (sbq[l].size() != 0) void'(sbq[l].pop_front());
      end else if (in_valid_s[l] && in_ready_s[l]) begin
        exp_t e;
        e.p   = model(opa_s[l], opb_s[l], sm_s[l]);
        e.cyc = 32'(cyc + 1);
        sbq[l].push_back(e);
      end
    end
  end

  // Probe requests from the stimulus (lane 0), checked by the monitor.
  int          pr_seq  = 0;
  int          pr_seen = 0;
  int          pr_id   = 0;
  logic [63:0] pr_exp  = '0;
  string       pr_nm   = "";

  logic        prev_ov   [3];
  logic        prev_hold [3];
  logic [63:0] prev_prod [3];

  // Output monitor: the only place comparisons are made and counted.
  always @(negedge clock) begin
    for (int l = 0; l < 3; l++) begin
      if (!reset) begin
        if (out_valid_s[l] && !prev_ov[l]) begin
          tests++;
          if (sbq[l].size() == 0) begin
            fails++;
            $display("FAIL spurious_valid lane%0d: out_valid=1 with nothing outstanding, required 0", l);
          end else if (cyc - int'(sbq[l][0].cyc) != nlat(l)) begin
            fails++;
            $display("FAIL latency lane%0d: got %0d cycles, required %0d", l,
                     cyc - int'(sbq[l][0].cyc), nlat(l));
          end
        end
        if (out_valid_s[l] && prev_hold[l]) begin
          tests++;
          if (prod_s[l] !== prev_prod[l]) begin
            fails++;
            $display("FAIL hold_stable lane%0d: product %h, required %h", l, prod_s[l], prev_prod[l]);
          end
        end
        if (out_valid_s[l]) begin
          tests++;
          if (busy_s[l] !== 1'b1 || in_ready_s[l] !== out_ready_s[l]) begin
            fails++;
            $display("FAIL done_ctrl lane%0d: busy=%b in_ready=%b, required busy=1 in_ready=%b",
                     l, busy_s[l], in_ready_s[l], out_ready_s[l]);
          end
        end
        if (out_valid_s[l] && out_ready_s[l] && !flush_s[l]) begin
          tests++;
          if (sbq[l].size() == 0) begin
            fails++;
            $display("FAIL unexpected_result lane%0d: product %h delivered with nothing outstanding", l, prod_s[l]);
          end else begin
            exp_t e;
            e = sbq[l].pop_front();
            if (prod_s[l] !== e.p) begin
              fails++;
              $display("FAIL product lane%0d: got %h, required %h", l, prod_s[l], e.p);
            end
          end
        end
      end
      prev_ov[l]   = out_valid_s[l];
      prev_hold[l] = out_valid_s[l] && !out_ready_s[l] && !flush_s[l] && !reset;
      prev_prod[l] = prod_s[l];
    end

    if (pr_seq != pr_seen) begin
      logic [63:0] act;
      pr_seen = pr_seq;
      tests++;
      case (pr_id)
        0:       act = 64'(out_valid_s[0]);
        1:       act = prod_s[0];
        2:       act = 64'(busy_s[0]);
        default: act = 64'(in_ready_s[0]);
      endcase
      if (act !== pr_exp) begin
        fails++;
        $display("FAIL %s: got %h, required %h", pr_nm, act, pr_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic probe(input int id, input string nm, input logic [63:0] e);
    pr_id  = id;
    pr_nm  = nm;
    pr_exp = e;
    pr_seq = pr_seq + 1;
    @(posedge clock); #1;
  endtask

  task automatic issue(input int l, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic keep);
    bit got = 0;
    in_valid_s[l] = 1'b1;
    opa_s[l]      = a;
    opb_s[l]      = b;
    sm_s[l]       = s;
    for (int k = 0; k < 400; k++) begin
      if (l > 0) out_ready_s[l] = ($urandom % 4) != 0;
      @(negedge clock);
      if (in_ready_s[l] && !flush_s[l]) begin
        got = 1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!got) begin
      $display("FAIL accept_timeout lane%0d: in_ready never rose, required 1", l);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "stopping on timeout");
    end
    @(posedge clock); #1;
    if (!keep) begin
      in_valid_s[l] = 1'b0;
      opa_s[l]      = $urandom;
      opb_s[l]      = $urandom;
    end
  endtask

  task automatic wait_valid(input int l);
    bit got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (out_valid_s[l]) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      $display("FAIL valid_timeout lane%0d: out_valid never rose, required 1", l);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "stopping on timeout");
    end
    @(posedge clock); #1;
  endtask

  task automatic run0(input logic [31:0] a, input logic [31:0] b, input logic s);
    issue(0, a, b, s, 1'b0);
    wait_valid(0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_lane(input int l);
    for (int i = 0; i < 1000; i++) begin
      issue(l, pick(), pick(), 1'($urandom % 2), 1'b0);
      repeat ($urandom % 3) begin
        out_ready_s[l] = ($urandom % 4) != 0;
        @(posedge clock); #1;
      end
    end
    out_ready_s[l] = 1'b1;
    repeat (40) @(posedge clock);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "stopping on watchdog");
  end

  initial begin
    for (int l = 0; l < 3; l++) begin
      in_valid_s[l]  = 1'b0;
      opa_s[l]       = '0;
      opb_s[l]       = '0;
      sm_s[l]        = 1'b0;
      flush_s[l]     = 1'b0;
      out_ready_s[l] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    probe(0, "rst_out_valid", 64'd0);
    probe(1, "rst_product", 64'd0);
    probe(2, "rst_busy", 64'd0);
    probe(3, "rst_in_ready", 64'd1);

    run0(32'd7, 32'd6, 1'b0);
    run0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run0(32'hFFFF_FFFD, 32'd5, 1'b1);
    run0(32'h8000_0000, 32'h8000_0000, 1'b1);
    run0(32'h8000_0000, 32'd1, 1'b1);
    for (int i = 0; i < 6; i++) run0($urandom, $urandom, 1'(i % 2));

    // Back-pressure in DONE, then take result and accept on the same edge,
    // then stream with in_valid and out_ready held high.
    out_ready_s[0] = 1'b0;
    issue(0, $urandom, $urandom, 1'b1, 1'b0);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      probe(3, "stall_in_ready", 64'd0);
      probe(2, "stall_busy", 64'd1);
    end
    out_ready_s[0] = 1'b1;
    for (int i = 0; i < 5; i++) issue(0, $urandom, $urandom, 1'($urandom % 2), 1'(i != 4));
    wait_valid(0);

    // Flush mid-run: no result may ever appear.
    issue(0, $urandom, $urandom, 1'b0, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    flush_s[0] = 1'b1;
    @(posedge clock); #1;
    flush_s[0] = 1'b0;
    probe(2, "flush_run_busy", 64'd0);
    probe(0, "flush_run_out_valid", 64'd0);
    probe(3, "flush_run_in_ready", 64'd1);
    repeat (40) @(posedge clock);
    #1;

    // Flush while holding a result in DONE.
    out_ready_s[0] = 1'b0;
    issue(0, $urandom, $urandom, 1'b1, 1'b0);
    wait_valid(0);
    flush_s[0] = 1'b1;
    @(posedge clock); #1;
    flush_s[0]     = 1'b0;
    out_ready_s[0] = 1'b1;
    probe(0, "flush_done_out_valid", 64'd0);
    probe(2, "flush_done_busy", 64'd0);

    // Flush in IDLE blocks a simultaneous accept.
    in_valid_s[0] = 1'b1;
    opa_s[0]      = 32'd5;
    opb_s[0]      = 32'd5;
    sm_s[0]       = 1'b0;
    flush_s[0]    = 1'b1;
    @(posedge clock); #1;
    in_valid_s[0] = 1'b0;
    flush_s[0]    = 1'b0;
    probe(2, "flush_idle_busy", 64'd0);
    run0(32'd9, 32'd9, 1'b0);

    // Reset mid-run, then a clean 3x4.
    issue(0, $urandom, $urandom, 1'b1, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    probe(0, "midrst_out_valid", 64'd0);
    probe(1, "midrst_product", 64'd0);
    probe(2, "midrst_busy", 64'd0);
    probe(3, "midrst_in_ready", 64'd1);
    run0(32'd3, 32'd4, 1'b0);

    // Randomised sweep on the STEP=2 and STEP=4 lanes.
    fork
      rand_lane(1);
      rand_lane(2);
    join

    repeat (3) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
